// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
//
// Shared definitions for the memory-port arbiter and the cache wrappers that
// talk to it: FSM state encodings, owner encodings, the default error word
// returned on a watchdog abort, and a helper that sizes the watchdog counter.
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    // FSM state encodings. Kept as plain constants so older wrappers that
    // compare raw state bits keep working.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Which cache miss path owns the memory port.
    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    // RV32I "addi x0, x0, 0". Handed back on a timed-out fetch so the core
    // executes harmlessly instead of decoding garbage.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Width of the watchdog counter. It only has to reach TIMEOUT_CYC-1, and
    // when the watchdog is disabled a single free-running bit is enough.
    function automatic int wd_width(input int timeout_cyc);
        return (timeout_cyc < 2) ? 1 : $clog2(timeout_cyc + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// -----------------------------------------------------------------------------
// rr_pick2
//
// Two-way round-robin picker for the memory-port arbiter. Purely
// combinational; the caller decides when the pick is acted on.
//
// Ports:
//   req_i       in   I-side request pending
//   req_d       in   D-side request pending
//   last_owner  in   side that was granted most recently
//   grant       out  at least one side is requesting
//   owner       out  side to grant (only meaningful when grant=1)
// -----------------------------------------------------------------------------
module rr_pick2
    import mem_port_arbiter_pkg::*;
(
    input  logic req_i,
    input  logic req_d,
    input  logic last_owner,
    output logic grant,
    output logic owner
);

    // A lone requester always wins. On a tie the side that did not go last
    // gets the port, which makes back-to-back traffic strictly alternate.
    always_comb begin
        grant = req_i | req_d;
        owner = OWNER_I;
        if (req_i && req_d) begin
            owner = ~last_owner;
        end else if (req_d) begin
            owner = OWNER_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single ROM/RAM port between the I-cache miss path (read-only)
// and the D-cache miss path (read/write). One transaction in flight at a time,
// round-robin grant, per-transaction watchdog. All outputs are registered.
//
// Transaction flow: IDLE (grant) -> BUSY (mem_valid held until mem_ready or
// watchdog expiry) -> RESP (one-cycle resp_ready to the owner) -> IDLE.
//
// Ports:
//   iCLK, iRST                 clock, synchronous active-high reset
//   i_req_valid / i_req_addr   I-side read request (held until i_resp_ready)
//   i_resp_data / i_resp_ready I-side read data and one-cycle completion
//   d_req_valid / d_req_rw /
//   d_req_addr / d_req_wdata   D-side request (held until d_resp_ready)
//   d_resp_data / d_resp_ready D-side read data and one-cycle completion
//   mem_valid / mem_rw /
//   mem_addr / mem_wdata       request toward memory
//   mem_rdata / mem_ready      response from memory
//   timeout_err                one-cycle pulse, aligned with RESP, on abort
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                TIMEOUT_CYC = 64,
    parameter logic [DATA_W-1:0] ERR_WORD    = DATA_W'(NOP_INSTR)
) (
    input  logic              iCLK,
    input  logic              iRST,

    input  logic              i_req_valid,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic [DATA_W-1:0] i_resp_data,
    output logic              i_resp_ready,

    input  logic              d_req_valid,
    input  logic              d_req_rw,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [DATA_W-1:0] d_req_wdata,
    output logic [DATA_W-1:0] d_resp_data,
    output logic              d_resp_ready,

    output logic              mem_valid,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,

    output logic              timeout_err
);

    localparam int              WD_W    = wd_width(TIMEOUT_CYC);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

    logic [1:0]      state;
    logic            owner;
    logic            last_owner;
    logic [WD_W-1:0] wd_count;

    logic            pick_grant;
    logic            pick_owner;
    logic            take_grant;
    logic            wd_expired;
    logic            done_ok;
    logic            done_timeout;
    logic            finish;
    logic [DATA_W-1:0] finish_data;

    rr_pick2 u_pick (
        .req_i      (i_req_valid),
        .req_d      (d_req_valid),
        .last_owner (last_owner),
        .grant      (pick_grant),
        .owner      (pick_owner)
    );

    // Decode the events the registers below react to. Requests are only
    // looked at in IDLE, which is what keeps a request that is still held
    // high during RESP from being granted a second time. mem_ready is only
    // looked at in BUSY, so stray pulses elsewhere do nothing. A real
    // mem_ready on the very cycle the watchdog expires wins over the abort.
    always_comb begin
        take_grant   = (state == ST_IDLE) && pick_grant;
        wd_expired   = (TIMEOUT_CYC != 0) && (wd_count == WD_LAST);
        done_ok      = (state == ST_BUSY) && mem_ready;
        done_timeout = (state == ST_BUSY) && !mem_ready && wd_expired;
        finish       = done_ok || done_timeout;
        finish_data  = done_ok ? mem_rdata : ERR_WORD;
    end

    // Main sequencer. RESP always lasts exactly one cycle so the owner sees a
    // single resp_ready pulse and has that cycle to drop its valid.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (take_grant) state <= ST_BUSY;
                ST_BUSY: if (finish)     state <= ST_RESP;
                ST_RESP:                 state <= ST_IDLE;
                default:                 state <= ST_IDLE;
            endcase
        end
    end

    // Ownership tracking. last_owner resets to the I-side so that a tie
    // straight out of reset goes to the D-side first.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            owner      <= OWNER_I;
            last_owner <= OWNER_I;
        end else if (take_grant) begin
            owner      <= pick_owner;
            last_owner <= pick_owner;
        end
    end

    // Watchdog: counts BUSY cycles that ended without mem_ready. It is cleared
    // on every grant, so each transaction gets the full TIMEOUT_CYC budget.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            wd_count <= '0;
        end else if (take_grant) begin
            wd_count <= '0;
        end else if (state == ST_BUSY) begin
            wd_count <= wd_count + 1'b1;
        end
    end

    // Memory-side request registers. They double as the latched copy of the
    // granted request, so they stay stable for the whole BUSY phase even if
    // the requester changes its inputs. The I-side can only read, so its
    // write enable and write data are forced to zero.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            mem_valid <= 1'b0;
            mem_rw    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (take_grant) begin
            mem_valid <= 1'b1;
            if (pick_owner == OWNER_D) begin
                mem_rw    <= d_req_rw;
                mem_addr  <= d_req_addr;
                mem_wdata <= d_req_wdata;
            end else begin
                mem_rw    <= 1'b0;
                mem_addr  <= i_req_addr;
                mem_wdata <= '0;
            end
        end else if (finish) begin
            mem_valid <= 1'b0;
        end
    end

    // I-side response. Data only changes when the I-side owns the finishing
    // transaction, so it holds its last value while the D-side is served.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            i_resp_ready <= 1'b0;
            i_resp_data  <= '0;
        end else begin
            i_resp_ready <= finish && (owner == OWNER_I);
            if (finish && (owner == OWNER_I)) begin
                i_resp_data <= finish_data;
            end
        end
    end

    // D-side response, mirror of the I-side one. Since only one owner exists
    // per transaction the two ready pulses can never overlap.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            d_resp_ready <= 1'b0;
            d_resp_data  <= '0;
        end else begin
            d_resp_ready <= finish && (owner == OWNER_D);
            if (finish && (owner == OWNER_D)) begin
                d_resp_data <= finish_data;
            end
        end
    end

    // Abort flag, registered alongside the response so it lines up with the
    // RESP cycle that carries ERR_WORD.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= done_timeout;
        end
    end

endmodule
